// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_loader: streams instruction words into memory, then boots the core  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prog_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              error_q, error_d;
  logic              xfer;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    checksum_d  = checksum_q;
    error_d     = 1'b0;
    xfer        = in_valid && (state_q == S_LOAD);

    // A word accepted at this edge is written even if abort also fires.
    if (xfer) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = base_q + ADDR_W'(idx_q);
      mem_wdata_d = in_data;
      checksum_d  = checksum_q + in_data;
      idx_d       = idx_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (word_count == '0) begin
            error_d = 1'b1;
          end else begin
            base_d     = base_addr;
            count_d    = word_count;
            idx_d      = '0;
            checksum_d = '0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer && (idx_q == count_q - CNT_W'(1))) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      checksum_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      checksum_q  <= checksum_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_HOLD);
  assign done      = (state_q == S_RUN);
  assign cpu_reset = (state_q != S_RUN);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign checksum  = checksum_q;
  assign error     = error_q;

endmodule
`default_nettype wire
